// File: rtl/clock_pkg.sv
// Shared types and 7-segment encoding for the board time-of-day clock.
package clock_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  typedef struct packed {
    bcd_t h10;
    bcd_t h1;
    bcd_t m10;
    bcd_t m1;
    bcd_t s10;
    bcd_t s1;
  } tod_t;

  // Active-low segments, bit0=a .. bit6=g
  localparam seg_t SEG_DIGIT [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                       7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam seg_t SEG_BLANK = 7'h7F;

  localparam bcd_t UNITS_MAX    = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t MIN_TENS_MAX = 4'd5;
  localparam bcd_t HR_TENS_MAX  = 4'd2;
  localparam bcd_t HR_UNITS_TOP = 4'd3;

  function automatic seg_t seg_encode(input bcd_t d);
    seg_t s;
    s = SEG_BLANK;
    for (int i = 0; i < 10; i++)
      if (d == bcd_t'(i)) s = SEG_DIGIT[i];
    return s;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for one switch.
module switch_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_i,
  input  logic sw_i,
  output logic level_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count samples that disagree with the accepted level; any agreeing sample restarts.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) level_d = sync2_q;
      else                              cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/clock_time_driver.sv
// BCD HH:MM:SS time-of-day core with switch-driven minute setting and direct 7-seg drive.
module clock_time_driver
  import clock_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int DEB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       RST,
  input  logic [1:0] SW,
  output logic [6:0] SEG1,
  output logic [6:0] SEG2,
  output logic [6:0] SEG3,
  output logic [6:0] SEG4,
  output logic [6:0] SEG5,
  output logic [6:0] SEG6,
  output logic       sec_pulse
);

  localparam int PW = $clog2(CLK_HZ);

  logic          set_mode, inc_lvl, inc_prev_q, inc, tick;
  logic [PW-1:0] pre_q, pre_d;
  tod_t          tod_q, tod_d;
  logic [5:0][6:0] seg_q, seg_d;
  logic          pulse_q;

  switch_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_set (
    .clk(clk), .rst_i(RST), .sw_i(SW[0]), .level_o(set_mode)
  );

  switch_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_inc (
    .clk(clk), .rst_i(RST), .sw_i(SW[1]), .level_o(inc_lvl)
  );

  function automatic tod_t inc_hour(input tod_t t);
    tod_t r;
    r = t;
    if (t.h10 == HR_TENS_MAX && t.h1 == HR_UNITS_TOP) begin
      r.h10 = '0;
      r.h1  = '0;
    end else if (t.h1 == UNITS_MAX) begin
      r.h1  = '0;
      r.h10 = t.h10 + 4'd1;
    end else begin
      r.h1  = t.h1 + 4'd1;
    end
    return r;
  endfunction

  function automatic tod_t inc_min(input tod_t t);
    tod_t r;
    r = t;
    if (t.m1 == UNITS_MAX) begin
      r.m1 = '0;
      if (t.m10 == MIN_TENS_MAX) begin
        r.m10 = '0;
        r     = inc_hour(r);
      end else begin
        r.m10 = t.m10 + 4'd1;
      end
    end else begin
      r.m1 = t.m1 + 4'd1;
    end
    return r;
  endfunction

  function automatic tod_t inc_sec(input tod_t t);
    tod_t r;
    r = t;
    if (t.s1 == UNITS_MAX) begin
      r.s1 = '0;
      if (t.s10 == SEC_TENS_MAX) begin
        r.s10 = '0;
        r     = inc_min(r);
      end else begin
        r.s10 = t.s10 + 4'd1;
      end
    end else begin
      r.s1 = t.s1 + 4'd1;
    end
    return r;
  endfunction

  // Prescaler is parked at zero while setting, so leaving set mode restarts a full second.
  assign tick = !set_mode && (pre_q == PW'(CLK_HZ - 1));
  assign inc  = set_mode && inc_lvl && !inc_prev_q;

  always_comb begin
    if (set_mode || tick) pre_d = '0;
    else                  pre_d = pre_q + PW'(1);
  end

  always_comb begin
    tod_d = tod_q;
    if (set_mode) begin
      tod_d.s10 = '0;
      tod_d.s1  = '0;
      if (inc) tod_d = inc_min(tod_d);
    end else if (tick) begin
      tod_d = inc_sec(tod_q);
    end
  end

  always_comb begin
    seg_d[0] = set_mode ? SEG_BLANK : seg_encode(tod_q.s1);
    seg_d[1] = set_mode ? SEG_BLANK : seg_encode(tod_q.s10);
    seg_d[2] = seg_encode(tod_q.m1);
    seg_d[3] = seg_encode(tod_q.m10);
    seg_d[4] = seg_encode(tod_q.h1);
    seg_d[5] = seg_encode(tod_q.h10);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      pre_q      <= '0;
      tod_q      <= '0;
      inc_prev_q <= 1'b0;
      pulse_q    <= 1'b0;
      seg_q      <= {6{SEG_DIGIT[0]}};
    end else begin
      pre_q      <= pre_d;
      tod_q      <= tod_d;
      inc_prev_q <= inc_lvl;
      pulse_q    <= tick;
      seg_q      <= seg_d;
    end
  end

  assign SEG1      = seg_q[0];
  assign SEG2      = seg_q[1];
  assign SEG3      = seg_q[2];
  assign SEG4      = seg_q[3];
  assign SEG5      = seg_q[4];
  assign SEG6      = seg_q[5];
  assign sec_pulse = pulse_q;

endmodule

// File: tb/tb_clock_time_driver.sv
// Self-checking bench: time kept as seconds-of-day, displays derived arithmetically.
module tb_clock_time_driver;

  localparam int CLK_HZ = 10;
  localparam int DEB    = 4;

  logic       clk = 1'b0;
  logic       RST;
  logic [1:0] SW;
  logic [6:0] SEG1, SEG2, SEG3, SEG4, SEG5, SEG6;
  logic       sec_pulse;

  int vec_cnt = 0;
  int err_cnt = 0;
  int npulse  = 0;
  int tot     = 0;

  always #5 clk = ~clk;

  clock_time_driver #(.CLK_HZ(CLK_HZ), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .RST(RST), .SW(SW),
    .SEG1(SEG1), .SEG2(SEG2), .SEG3(SEG3), .SEG4(SEG4), .SEG5(SEG5), .SEG6(SEG6),
    .sec_pulse(sec_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (sec_pulse === 1'b1) npulse++;
  endtask

  function automatic logic [6:0] bseg(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic chk_disp(input string tag, input int t, input bit blank);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    chk({tag, ".seg1"}, 32'(SEG1), blank ? 32'h7F : 32'(bseg(s % 10)));
    chk({tag, ".seg2"}, 32'(SEG2), blank ? 32'h7F : 32'(bseg(s / 10)));
    chk({tag, ".seg3"}, 32'(SEG3), 32'(bseg(m % 10)));
    chk({tag, ".seg4"}, 32'(SEG4), 32'(bseg(m / 10)));
    chk({tag, ".seg5"}, 32'(SEG5), 32'(bseg(h % 10)));
    chk({tag, ".seg6"}, 32'(SEG6), 32'(bseg(h / 10)));
  endtask

  initial begin
    int p0, first, k, len, n;

    RST = 1'b1;
    SW  = 2'b00;

    // Reset: all digits zero from the very first reset edge
    cyc();
    chk_disp("rst0", 0, 1'b0);
    chk("rst0.pulse", 32'(sec_pulse), 32'd0);
    cyc();
    chk_disp("rst1", 0, 1'b0);
    chk("rst1.pulse", 32'(sec_pulse), 32'd0);
    RST    = 1'b0;
    npulse = 0;

    // 100 cycles of running = 10 seconds
    repeat (101) cyc();
    chk("run.pulses", npulse, 10);
    tot = 10;
    chk_disp("run10", tot, 1'b0);

    // Advance to 00:00:37 (seconds land every CLK_HZ cycles after release)
    repeat (269) cyc();
    chk("s37.pulse", 32'(sec_pulse), 32'd1);
    chk("s37.count", npulse, 37);
    cyc();
    tot = 37;
    chk_disp("s37", tot, 1'b0);

    // Enter set mode: seconds cleared and blanked, no ticks
    SW[0] = 1'b1;
    repeat (10) cyc();
    tot = 0;
    chk_disp("setentry", tot, 1'b1);
    p0 = npulse;
    repeat (50) cyc();
    chk("set.nopulse", npulse, p0);

    // Debounce: a short glitch is rejected, a long press increments once
    SW[1] = 1'b1; repeat (3) cyc(); SW[1] = 1'b0; repeat (10) cyc();
    chk_disp("deb.short", tot, 1'b1);
    SW[1] = 1'b1; repeat (6) cyc(); SW[1] = 1'b0; repeat (10) cyc();
    tot = 60;
    chk_disp("deb.long", tot, 1'b1);
    for (int i = 0; i < 8; i++) begin
      len = int'($urandom_range(1, 8));
      SW[1] = 1'b1; repeat (len) cyc(); SW[1] = 1'b0; repeat (10) cyc();
      if (len >= DEB) tot = ((tot / 60 + 1) % 1440) * 60;
      chk_disp($sformatf("deb.rnd%0d_len%0d", i, len), tot, 1'b1);
    end
    chk("deb.nopulse", npulse, p0);

    // Exit set mode: first second exactly CLK_HZ cycles after acceptance (2 sync + DEB)
    SW[0] = 1'b0;
    p0    = npulse;
    first = 0;
    n     = int'($urandom_range(60, 150));
    for (k = 1; k <= n; k++) begin
      if (k == 20) SW[1] = 1'b1;   // minute presses must be ignored while running
      if (k == 30) SW[1] = 1'b0;
      cyc();
      if (sec_pulse === 1'b1 && first == 0) first = k;
    end
    while ((k - 1 - 16) % 10 != 0) begin
      cyc();
      k++;
    end
    k = k - 1;
    chk("exit.first", first, 16);
    chk("exit.sync_pulse", 32'(sec_pulse), 32'd1);
    chk("exit.pulses", npulse - p0, (k - 16) / 10 + 1);
    tot = tot + (k - 16) / 10 + 1;
    cyc();
    chk_disp("exit.run", tot, 1'b0);

    // Wrap: set 23:59 then run to 23:59:59 and over midnight
    SW[0] = 1'b1;
    repeat (10) cyc();
    tot = (tot / 60) * 60;
    chk_disp("wrap.set", tot, 1'b1);
    p0 = npulse;
    n  = (1439 - tot / 60) % 1440;
    repeat (n) begin
      SW[1] = 1'b1; repeat (6) cyc();
      SW[1] = 1'b0; repeat (6) cyc();
    end
    repeat (10) cyc();
    tot = 1439 * 60;
    chk_disp("wrap.2359", tot, 1'b1);
    chk("wrap.nopulse", npulse, p0);
    SW[0] = 1'b0;
    repeat (596) cyc();
    chk("wrap.p59", 32'(sec_pulse), 32'd1);
    cyc();
    chk("wrap.cnt59", npulse - p0, 59);
    tot = tot + 59;
    chk_disp("wrap.235959", tot, 1'b0);
    repeat (9) cyc();
    chk("wrap.p60", 32'(sec_pulse), 32'd1);
    cyc();
    tot = 0;
    chk_disp("wrap.000000", tot, 1'b0);

    // Reset mid-second and mid-debounce
    repeat (29) cyc();
    chk("mid.p3", 32'(sec_pulse), 32'd1);
    tot = 3;
    repeat (4) cyc();
    SW[0] = 1'b1;
    repeat (3) cyc();
    RST = 1'b1;
    p0  = npulse;
    cyc();
    chk_disp("mid.rst", 0, 1'b0);
    chk("mid.rst.pulse", 32'(sec_pulse), 32'd0);
    RST = 1'b0;
    tot = 0;
    repeat (6) cyc();
    chk("mid.preaccept", 32'(SEG1), 32'h40);
    cyc();
    chk_disp("mid.accept", tot, 1'b1);
    repeat (20) cyc();
    chk("mid.nopulse", npulse, p0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
